// File: rtl/sys_defs.sv
// Shared system definitions: datapath widths, ALU opcodes and the
// reservation-station payload carried from a line into an issue slot.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int PCLEN     = 32;
  localparam int OLEN      = 12;
  localparam int PRF       = 64;
  localparam int ROB       = 16;
  localparam int PRF_IDX_W = $clog2(PRF);
  localparam int ROB_IDX_W = $clog2(ROB);

  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_AND    = 5'h02,
    ALU_OR     = 5'h03,
    ALU_XOR    = 5'h04,
    ALU_SLL    = 5'h05,
    ALU_SRL    = 5'h06,
    ALU_SRA    = 5'h07,
    ALU_SLT    = 5'h08,
    ALU_SLTU   = 5'h09,
    ALU_MUL    = 5'h0a,
    ALU_MULH   = 5'h0b,
    ALU_MULHSU = 5'h0c,
    ALU_MULHU  = 5'h0d
  } ALU_FUNC;

  typedef struct packed {
    logic [XLEN-1:0]      opa;
    logic [XLEN-1:0]      opb;
    logic [PRF_IDX_W-1:0] dest_PRF_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PCLEN-1:0]     PC;
    ALU_FUNC              Operation;
    logic [OLEN-1:0]      offset;
    logic                 rd_mem;
    logic                 wr_mem;
  } RS_PACKET;

endpackage

// File: rtl/rs_issue_select_if.sv
// Bundle between the reservation station, the issue selector and the
// functional-unit lanes. The selector sits on the slave side.
interface rs_issue_select_if #(
  parameter int RS   = 16,
  parameter int WAYS = 3
);

  logic [RS-1:0]                   rs_ready;
  sys_defs::RS_PACKET [RS-1:0]     rs_pkt;
  logic [WAYS-1:0]                 fu_stall;
  logic                            squash;
  logic [RS-1:0]                   rs_clear;
  logic [WAYS-1:0]                 issue_valid;
  sys_defs::RS_PACKET [WAYS-1:0]   issue_pkt;

  modport master (
    output rs_ready, rs_pkt, fu_stall, squash,
    input  rs_clear, issue_valid, issue_pkt
  );

  modport slave (
    input  rs_ready, rs_pkt, fu_stall, squash,
    output rs_clear, issue_valid, issue_pkt
  );

endinterface

// File: rtl/rs_issue_select_rr_picker.sv
// Rotating-priority first-one finder: returns the first set request at or
// after ptr, wrapping from RS-1 back to 0.
module rs_rr_picker #(
  parameter  int RS = 16,
  localparam int PW = (RS > 1) ? $clog2(RS) : 1
) (
  input  logic [RS-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [RS-1:0] grant,
  output logic [PW-1:0] idx,
  output logic          found
);

  localparam logic [PW:0] RS_W = (PW+1)'(RS);

  logic [PW:0] pos;

  // Walk the ring once starting at ptr and keep the first request seen.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < RS; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= RS_W) pos = pos - RS_W;
      if (!found && req[pos[PW-1:0]]) begin
        found                = 1'b1;
        idx                  = pos[PW-1:0];
        grant[pos[PW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_issue_select.sv
// Issue selector: grants up to one ready RS line per open issue slot in
// round-robin order and registers the chosen payloads into the slots.
module rs_issue_select
  import sys_defs::*;
#(
  parameter int RS   = 16,
  parameter int WAYS = 3
) (
  input  logic             clock,
  input  logic             reset,
  rs_issue_select_if.slave bus
);

  localparam int PW = (RS > 1) ? $clog2(RS) : 1;
  localparam int CW = $clog2(WAYS + 1);
  localparam logic [PW-1:0] LAST_LINE = PW'(RS - 1);

  logic [PW-1:0]        ptr_reg, ptr_next;
  logic [WAYS-1:0]      valid_reg, valid_next;
  RS_PACKET [WAYS-1:0]  pkt_reg, pkt_next;

  logic [WAYS-1:0]      slot_open;
  logic [CW-1:0]        n_open;
  logic [CW-1:0]        slot_rank [WAYS];
  logic                 grant_en;

  logic [RS-1:0]        taken      [WAYS+1];
  logic [RS-1:0]        stage_req  [WAYS];
  logic [RS-1:0]        stage_grant[WAYS];
  logic [PW-1:0]        stage_idx  [WAYS];
  logic [WAYS-1:0]      stage_found;
  logic [WAYS-1:0]      stage_active;

  // No grants during reset or flush; stalled full slots are simply not open.
  assign grant_en  = reset && !bus.squash;
  assign slot_open = ~valid_reg | ~bus.fu_stall;

  // Count open slots and give each slot its position among the open ones,
  // so stage s feeds the s-th open slot.
  always_comb begin
    n_open = '0;
    for (int w = 0; w < WAYS; w++) begin
      slot_rank[w] = n_open;
      if (slot_open[w]) n_open = n_open + CW'(1);
    end
  end

  // Picker chain: each stage only sees lines that earlier stages left over,
  // and only stages with an open slot behind them may request at all.
  assign taken[0] = '0;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_stage
      assign stage_active[gi] = grant_en && (CW'(gi) < n_open);
      assign stage_req[gi]    = bus.rs_ready & ~taken[gi] & {RS{stage_active[gi]}};

      rs_rr_picker #(.RS(RS)) u_picker (
        .req   (stage_req[gi]),
        .ptr   (ptr_reg),
        .grant (stage_grant[gi]),
        .idx   (stage_idx[gi]),
        .found (stage_found[gi])
      );

      assign taken[gi+1] = taken[gi] | stage_grant[gi];
    end
  endgenerate

  assign bus.rs_clear    = taken[WAYS];
  assign bus.issue_valid = valid_reg;
  assign bus.issue_pkt   = pkt_reg;

  // Next slot contents and pointer; squash empties every slot regardless of stall.
  always_comb begin
    ptr_next   = ptr_reg;
    valid_next = valid_reg;
    pkt_next   = pkt_reg;
    for (int s = 0; s < WAYS; s++) begin
      if (stage_found[s]) ptr_next = (stage_idx[s] == LAST_LINE) ? '0 : stage_idx[s] + PW'(1);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (slot_open[w]) begin
        valid_next[w] = 1'b0;
        for (int s = 0; s < WAYS; s++) begin
          if (slot_rank[w] == CW'(s) && stage_found[s]) begin
            valid_next[w] = 1'b1;
            pkt_next[w]   = bus.rs_pkt[stage_idx[s]];
          end
        end
      end
    end
    if (bus.squash) begin
      valid_next = '0;
      ptr_next   = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_reg   <= '0;
      valid_reg <= '0;
      pkt_reg   <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      valid_reg <= valid_next;
      pkt_reg   <= pkt_next;
    end
  end

endmodule
